// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin valid/ready arbiter sharing one fifo write port, with
//            burst locking. Define FIFO_ARB_STATS_EN for per-producer beat counters.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int REQ_N      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int PTR_W      = $clog2(REQ_N)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQ_N-1:0]            req_val,
  input  logic [REQ_N-1:0]            req_last,
  input  logic [REQ_N*DATA_WIDTH-1:0] req_data,
  output logic [REQ_N-1:0]            req_rdy,
  input  logic                        fifo_wr_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic [REQ_N-1:0]            grant,
`ifdef FIFO_ARB_STATS_EN
  input  logic                        stats_clr,
  output logic [REQ_N*16-1:0]         beat_count,
`endif
  output logic                        locked
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQ_N - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           fsm_q, fsm_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0] w_win;
  logic             w_win_vld;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
  endfunction

  // Downward scan so the lowest offset from ptr is the last (winning) hit.
  always_comb begin
    logic [PTR_W:0] w_cand;
    w_cand    = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    if (fsm_q == LOCK) begin
      w_win     = owner_q;
      w_win_vld = req_val[owner_q];
    end else begin
      for (int k = REQ_N - 1; k >= 0; k--) begin
        w_cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
        if (w_cand >= (PTR_W+1)'(REQ_N)) w_cand = w_cand - (PTR_W+1)'(REQ_N);
        if (req_val[w_cand[PTR_W-1:0]]) begin
          w_win     = w_cand[PTR_W-1:0];
          w_win_vld = 1'b1;
        end
      end
    end
    w_win_vld = w_win_vld & reset;
  end

  always_comb begin
    grant        = '0;
    fifo_wr_data = '0;
    grant[w_win] = w_win_vld;
    for (int i = 0; i < REQ_N; i++) begin
      if (grant[i]) fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en = w_win_vld & fifo_wr_ready;
  assign req_rdy    = grant & {REQ_N{fifo_wr_ready}};
  assign locked     = (fsm_q == LOCK);

  always_comb begin
    fsm_d      = fsm_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (fifo_wr_en) begin
      if (fsm_q == IDLE) begin
        if (req_last[w_win] || MAX_BURST == 1) begin
          ptr_d = next_idx(w_win);
        end else begin
          fsm_d      = LOCK;
          owner_d    = w_win;
          beat_cnt_d = CNT_W'(1);
        end
      end else if (req_last[owner_q] || beat_cnt_q == CNT_END) begin
        fsm_d      = IDLE;
        ptr_d      = next_idx(owner_q);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar i = 0; i < REQ_N; i++) begin : g_stats
      logic [15:0] cnt_q, cnt_d;

      // Clear wins over a same-cycle beat; counting saturates.
      always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
          cnt_d = '0;
        end else if (req_val[i] && req_rdy[i] && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign beat_count[i*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_val, req_last, req_rdy, grant;
  logic [N*W-1:0] req_data;
  logic           fifo_wr_ready, fifo_wr_en, locked;
  logic [W-1:0]   fifo_wr_data;
`ifdef FIFO_ARB_STATS_EN
  logic           stats_clr;
  logic [N*16-1:0] beat_count;
`endif

  fifo_wr_arbiter #(.REQ_N(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_last(req_last), .req_data(req_data), .req_rdy(req_rdy),
    .fifo_wr_ready(fifo_wr_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant(grant),
`ifdef FIFO_ARB_STATS_EN
    .stats_clr(stats_clr), .beat_count(beat_count),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] rdy;
    logic         wr;
    logic         locked;
    logic [W-1:0] data;
  } st_t;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [W-1:0] data;
  } wr_t;

  st_t sq[$];
  wr_t wq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model: "which producer owns the port" plus how many beats it has sent.
  bit m_locked;
  int m_owner, m_ptr, m_beats;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_beats  = 0;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    logic [N*W-1:0] d;
    int  win;
    bit  wv;
    st_t e;
    wr_t w;
    d = N*W'($urandom);
    req_val = v; req_last = l; req_data = d; fifo_wr_ready = r;
    wv = 0; win = 0;
    if (m_locked) begin
      win = m_owner;
      wv  = v[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!wv && v[(m_ptr + k) % N]) begin
          wv  = 1;
          win = (m_ptr + k) % N;
        end
      end
    end
    e.grant  = wv ? (N'(1) << win) : '0;
    e.rdy    = r ? e.grant : '0;
    e.wr     = wv && r;
    e.locked = m_locked;
    e.data   = wv ? d[win*W +: W] : '0;
    sq.push_back(e);
    if (e.wr) begin
      w.grant = e.grant;
      w.data  = e.data;
      wq.push_back(w);
      if (!m_locked) begin
        m_beats = 1;
        if (l[win] || MB == 1) m_ptr = (win + 1) % N;
        else begin
          m_locked = 1;
          m_owner  = win;
        end
      end else begin
        m_beats++;
        if (l[m_owner] || m_beats == MB) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    st_t s;
    wr_t w;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("grant",  32'(grant),        32'(s.grant));
      chk("req_rdy", 32'(req_rdy),     32'(s.rdy));
      chk("wr_en",  32'(fifo_wr_en),   32'(s.wr));
      chk("locked", 32'(locked),       32'(s.locked));
      chk("data",   32'(fifo_wr_data), 32'(s.data));
    end
    if (fifo_wr_en) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got data %0h expected no write", fifo_wr_data);
      end else begin
        w = wq.pop_front();
        chk("wr_data", 32'(fifo_wr_data), 32'(w.data));
        chk("wr_src",  32'(grant),        32'(w.grant));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FIFO_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    reset = 1'b0; req_val = '1; req_last = '1; req_data = '0; fifo_wr_ready = 1'b1;
    model_reset();
    #7;
    chk("rst_grant",  32'(grant),      0);
    chk("rst_wr_en",  32'(fifo_wr_en), 0);
    chk("rst_rdy",    32'(req_rdy),    0);
    chk("rst_locked", 32'(locked),     0);
    #1 reset = 1'b1;

    repeat (5) cycle(4'b1111, 4'b1111, 1'b1);
    repeat (4) cycle(4'b0101, 4'b1111, 1'b1);

    // Producer 1: 6-beat packet, producer 3 joins after beat 1.
    cycle(4'b0010, 4'b0000, 1'b1);
    repeat (3) cycle(4'b1010, 4'b1000, 1'b1);
    cycle(4'b1010, 4'b1000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1);

    // Lock on producer 2, then a 2-cycle bubble while producer 0 waits.
    cycle(4'b0100, 4'b0000, 1'b1);
    repeat (2) cycle(4'b0001, 4'b0000, 1'b1);
    cycle(4'b0101, 4'b0000, 1'b1);
    cycle(4'b0101, 4'b0100, 1'b1);

    // Backpressure mid-burst.
    cycle(4'b0010, 4'b0000, 1'b1);
    repeat (3) cycle(4'b0011, 4'b0000, 1'b0);
    repeat (3) cycle(4'b0011, 4'b0000, 1'b1);

    // Reset while locked on producer 3.
    cycle(4'b1000, 4'b0000, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_locked", 32'(locked),     0);
    chk("midrst_grant",  32'(grant),      0);
    chk("midrst_wr_en",  32'(fifo_wr_en), 0);
    #1 reset = 1'b1;
    cycle(4'b1111, 4'b1111, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));

`ifdef FIFO_ARB_STATS_EN
    repeat (70000) cycle(4'b0001, 4'b0001, 1'b1);
    chk("stats_sat", 32'(beat_count[15:0]), 32'hFFFF);
    stats_clr = 1'b1;
    cycle(4'b0001, 4'b0001, 1'b1);
    stats_clr = 1'b0;
    chk("stats_clr_lo", beat_count[31:0],  0);
    chk("stats_clr_hi", beat_count[63:32], 0);
`endif

    cycle(4'b0000, 4'b0000, 1'b1);
    chk("wq_drained", 32'(wq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo write port between REQ_N independent producers. Each producer uses a valid/ready handshake; the arbiter selects one per cycle, muxes its data onto the fifo write port, and honours fifo backpressure (wr_ready). Optional burst locking keeps the grant on one producer for up to MAX_BURST consecutive beats, so a packet lands contiguously in the fifo.

Parameters:
REQ_N, 4, number of producers (>=2)
DATA_WIDTH, 8, beat width; must match the fifo DATA_WIDTH
MAX_BURST, 4, maximum beats per lock; 1 disables locking
PTR_W, $clog2(REQ_N), width of the priority pointer and owner index

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous active-low reset; state clears immediately while low
req_val  input  REQ_N  bit i: producer i has a beat
req_last  input  REQ_N  bit i: producer i's current beat ends its packet
req_data  input  REQ_N*DATA_WIDTH  producer i's data in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_rdy  output  REQ_N  bit i: producer i's beat is accepted this cycle
fifo_wr_ready  input  1  fifo can accept a write
fifo_wr_en  output  1  write strobe to the fifo
fifo_wr_data  output  DATA_WIDTH  data to the fifo
grant  output  REQ_N  one-hot current selection; zero when nothing is selected
locked  output  1  high while in LOCK

Behaviour:
- State: ptr (PTR_W bits), owner (PTR_W bits), beat_cnt ($clog2(MAX_BURST)+1 bits), fsm in {IDLE, LOCK}.
- Reset (reset low, async): fsm=IDLE, ptr=0, owner=0, beat_cnt=0. Outputs follow combinationally: grant=0, fifo_wr_en=0, req_rdy=0, locked=0 while req_val=0. Reset mid-burst drops the lock; no partial-packet recovery.
- Selection is combinational, so a beat is accepted in the same cycle it is granted (0-cycle latency).
  - IDLE: winner is the first i with req_val[i]=1, searching ptr, ptr+1, ... and wrapping mod REQ_N.
  - LOCK: winner is owner, regardless of other requests.
- grant is one-hot of the winner. In LOCK, grant is zero when req_val[owner]=0, which is a bubble: no write, lock held.
- fifo_wr_en = |grant & fifo_wr_ready.
- fifo_wr_data = req_data slice of the winner; don't-care (drive 0) when grant=0.
- req_rdy = grant & {REQ_N{fifo_wr_ready}}. A beat transfers iff req_val[i] & req_rdy[i].
- Accept means fifo_wr_en=1. With winner g on accept:
  - IDLE, and (req_last[g]=1 or MAX_BURST=1): stay IDLE; ptr <= (g+1) mod REQ_N.
  - IDLE, otherwise: go to LOCK; owner <= g; beat_cnt <= 1.
  - LOCK, and (req_last[owner]=1 or beat_cnt=MAX_BURST-1): go to IDLE; ptr <= (owner+1) mod REQ_N; beat_cnt <= 0.
  - LOCK, otherwise: beat_cnt <= beat_cnt+1.
- fifo_wr_ready=0: no state change, no transfer; grant still shows the selection.
- No requests in IDLE: ptr holds.
- Wrap: when REQ_N is not a power of two, ptr and owner increments wrap at REQ_N-1 -> 0.
- locked = (fsm==LOCK).

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output port beat_count (REQ_N*16 bits), one 16-bit counter per producer. Each counter increments on every accepted beat from that producer and saturates at 16'hFFFF. Cleared by reset. Adds input stats_clr (1 bit), a synchronous clear of all counters; a beat accepted in the same cycle as stats_clr leaves that counter at 0.
- Undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Test Plan:
- Reset low with req_val=4'b1111 -> grant=0, fifo_wr_en=0. Release with fifo_wr_ready=1 and req_last=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, one write per cycle, data matches each slice.
- req_val=4'b0101, all beats last, fifo_wr_ready=1 -> producers alternate 0, 2, 0, 2; ptr skips idle producers.
- Producer 1 alone sends 6 beats with req_last only on beat 6, MAX_BURST=4 -> locked rises after beat 1 and stays high through beat 4; IDLE after beat 4; producer 3 requesting meanwhile is granted before producer 1's beats 5-6.
- In LOCK with owner=2, drop req_val[2] for 2 cycles while req_val[0]=1 -> grant=0 and fifo_wr_en=0 for 2 cycles; owner 2 resumes afterwards and req_rdy[0] stays 0 throughout.
- Hold fifo_wr_ready=0 for 3 cycles mid-burst -> no writes, req_rdy=0, beat_cnt and ptr unchanged. Assert reset low mid-lock -> locked=0 immediately and ptr=0 after release.
- FIFO_ARB_STATS_EN defined: 70000 accepted beats from producer 0 -> beat_count[15:0]=16'hFFFF (saturated). Pulse stats_clr -> all counters read 0.
